// File: rtl/player_action_fsm.sv
// -----------------------------------------------------------------------------
// player_action_fsm
//
// Per-player action state machine for a side-scrolling fighter. Once per video
// frame (tick=1) it decides the next action from the controller levels and the
// collision "hit" level. It also tracks horizontal position, jump height and
// facing direction.
//
// Ports
//   clk            in   system clock (single clock domain)
//   reset          in   synchronous, active-high reset
//   tick           in   one-cycle frame strobe; state only advances on ticks
//   left/right     in   horizontal stick levels
//   up/down        in   jump / crouch levels
//   attack         in   attack button level (edge-qualified internally)
//   pery           in   parry button level
//   hit            in   collision level, sampled on ticks
//   state          out  0 IDLE, 1 WALK_L, 2 WALK_R, 3 JUMP, 4 CROUCH,
//                       5 ATTACK, 6 PARRY, 7 HITSTUN
//   x_pos          out  horizontal position, clamped to [X_MIN, X_MAX]
//   y_off          out  height above ground while jumping
//   facing_right   out  1 = facing right
//   attack_active  out  registered decode of ATTACK
//   parry_active   out  registered decode of PARRY
//   parry_success  out  one-cycle pulse when a hit lands during PARRY
// -----------------------------------------------------------------------------
module player_action_fsm #(
  parameter logic [9:0] X_MIN          = 10'd16,
  parameter logic [9:0] X_MAX          = 10'd560,
  parameter logic [9:0] X_START        = 10'd100,
  parameter int         WALK_STEP      = 4,
  parameter int         ATTACK_TICKS   = 12,
  parameter int         PARRY_TICKS    = 8,
  parameter int         HIT_TICKS      = 16,
  parameter int         KNOCKBACK      = 24,
  parameter int         COOLDOWN_TICKS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       left,
  input  logic       right,
  input  logic       up,
  input  logic       down,
  input  logic       attack,
  input  logic       pery,
  input  logic       hit,
  output logic [2:0] state,
  output logic [9:0] x_pos,
  output logic [6:0] y_off,
  output logic       facing_right,
  output logic       attack_active,
  output logic       parry_active,
  output logic       parry_success
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WALK_L  = 3'd1,
    S_WALK_R  = 3'd2,
    S_JUMP    = 3'd3,
    S_CROUCH  = 3'd4,
    S_ATTACK  = 3'd5,
    S_PARRY   = 3'd6,
    S_HITSTUN = 3'd7
  } state_e;

  // Parameters narrowed once so every comparison below is width-matched.
  localparam logic [9:0] STEP       = 10'(WALK_STEP);
  localparam logic [9:0] KB         = 10'(KNOCKBACK);
  localparam logic [7:0] ATTACK_LEN = 8'(ATTACK_TICKS);
  localparam logic [7:0] PARRY_LEN  = 8'(PARRY_TICKS);
  localparam logic [7:0] HIT_LEN    = 8'(HIT_TICKS);
  localparam logic [7:0] COOL_LOAD  = 8'(COOLDOWN_TICKS);
  localparam logic [7:0] JUMP_RISE  = 8'd8;
  localparam logic [7:0] JUMP_LEN   = 8'd16;
  localparam logic [6:0] JUMP_DY    = 7'd4;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e     state_q,         state_d;
  logic [9:0] x_q,             x_d;
  logic [6:0] y_q,             y_d;
  logic       facing_q,        facing_d;
  logic [7:0] cnt_q,           cnt_d;
  logic [7:0] cool_q,          cool_d;
  logic       attack_prev_q,   attack_prev_d;
  logic       attack_active_q, attack_active_d;
  logic       parry_active_q,  parry_active_d;
  logic       parry_success_q, parry_success_d;

  // Decoded inputs
  logic       attack_edge;
  logic       move_left;
  logic       move_right;
  logic [7:0] cnt_inc;

  // ---------------------------------------------------------------------------
  // Saturating position helpers. They use 11-bit arithmetic, so neither the
  // subtraction nor the addition can wrap before the clamp is applied.
  // ---------------------------------------------------------------------------
  function automatic logic [9:0] sat_left(input logic [9:0] x, input logic [9:0] amt);
    logic [10:0] floor_sum;
    floor_sum = {1'b0, X_MIN} + {1'b0, amt};
    if ({1'b0, x} < floor_sum) begin
      sat_left = X_MIN;
    end else begin
      sat_left = x - amt;
    end
  endfunction

  function automatic logic [9:0] sat_right(input logic [9:0] x, input logic [9:0] amt);
    logic [10:0] sum;
    sum = {1'b0, x} + {1'b0, amt};
    if (sum > {1'b0, X_MAX}) begin
      sat_right = X_MAX;
    end else begin
      sat_right = sum[9:0];
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    x_d             = x_q;
    y_d             = y_q;
    facing_d        = facing_q;
    cnt_d           = cnt_q;
    cool_d          = cool_q;
    attack_prev_d   = attack_prev_q;
    attack_active_d = attack_active_q;
    parry_active_d  = parry_active_q;
    // The success flag is a pulse, not held state: it falls on the cycle
    // after it rises, even though no tick has occurred.
    parry_success_d = 1'b0;

    attack_edge = attack & ~attack_prev_q;
    move_left   = left & ~right;
    move_right  = right & ~left;
    cnt_inc     = cnt_q + 8'd1;

    if (tick) begin
      attack_prev_d = attack;

      if (cool_q != 8'd0) begin
        cool_d = cool_q - 8'd1;
      end

      unique case (state_q)
        S_IDLE, S_WALK_L, S_WALK_R, S_CROUCH: begin
          cnt_d = 8'd0;
          if (hit) begin
            state_d = S_HITSTUN;
            y_d     = 7'd0;
            x_d     = facing_q ? sat_left(x_q, KB) : sat_right(x_q, KB);
          end else if (attack_edge && (cool_q == 8'd0)) begin
            state_d = S_ATTACK;
          end else if (pery) begin
            state_d = S_PARRY;
          end else if (up) begin
            state_d = S_JUMP;
          end else if (down) begin
            state_d = S_CROUCH;
          end else if (move_left) begin
            // Walking moves on the tick that enters or continues the walk.
            state_d  = S_WALK_L;
            x_d      = sat_left(x_q, STEP);
            facing_d = 1'b0;
          end else if (move_right) begin
            state_d  = S_WALK_R;
            x_d      = sat_right(x_q, STEP);
            facing_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end

        S_JUMP: begin
          if (hit) begin
            state_d = S_HITSTUN;
            cnt_d   = 8'd0;
            y_d     = 7'd0;
            x_d     = facing_q ? sat_left(x_q, KB) : sat_right(x_q, KB);
          end else begin
            // Air control: the stick still steers; other buttons are ignored.
            if (move_left) begin
              x_d      = sat_left(x_q, STEP);
              facing_d = 1'b0;
            end else if (move_right) begin
              x_d      = sat_right(x_q, STEP);
              facing_d = 1'b1;
            end
            // cnt_inc is the 1-based index of this airborne tick.
            if (cnt_inc <= JUMP_RISE) begin
              y_d = y_q + JUMP_DY;
            end else begin
              y_d = y_q - JUMP_DY;
            end
            if (cnt_inc == JUMP_LEN) begin
              state_d = S_IDLE;
              cnt_d   = 8'd0;
              y_d     = 7'd0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end

        S_ATTACK: begin
          if (hit) begin
            // An interrupted swing still starts the cooldown.
            state_d = S_HITSTUN;
            cnt_d   = 8'd0;
            y_d     = 7'd0;
            x_d     = facing_q ? sat_left(x_q, KB) : sat_right(x_q, KB);
            cool_d  = COOL_LOAD;
          end else if (cnt_inc == ATTACK_LEN) begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
            cool_d  = COOL_LOAD;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        S_PARRY: begin
          // A hit is absorbed: no state change, only the success pulse.
          parry_success_d = hit;
          if (cnt_inc == PARRY_LEN) begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        S_HITSTUN: begin
          if (cnt_inc == HIT_LEN) begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        default: begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end
      endcase

      attack_active_d = (state_d == S_ATTACK);
      parry_active_d  = (state_d == S_PARRY);
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      x_q             <= X_START;
      y_q             <= 7'd0;
      facing_q        <= 1'b1;
      cnt_q           <= 8'd0;
      cool_q          <= 8'd0;
      attack_prev_q   <= 1'b0;
      attack_active_q <= 1'b0;
      parry_active_q  <= 1'b0;
      parry_success_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      x_q             <= x_d;
      y_q             <= y_d;
      facing_q        <= facing_d;
      cnt_q           <= cnt_d;
      cool_q          <= cool_d;
      attack_prev_q   <= attack_prev_d;
      attack_active_q <= attack_active_d;
      parry_active_q  <= parry_active_d;
      parry_success_q <= parry_success_d;
    end
  end

  assign state         = state_q;
  assign x_pos         = x_q;
  assign y_off         = y_q;
  assign facing_right  = facing_q;
  assign attack_active = attack_active_q;
  assign parry_active  = parry_active_q;
  assign parry_success = parry_success_q;

endmodule

// File: tb/tb_player_action_fsm.sv
// -----------------------------------------------------------------------------
// tb_player_action_fsm
//
// Scoreboard bench for player_action_fsm with default parameters. Before each
// clock step, expected output values are queued. After the step, #1 past the
// rising edge, the queue is drained and each entry is compared with the DUT.
// -----------------------------------------------------------------------------
module tb_player_action_fsm;

  logic       clk = 1'b0;
  logic       reset, tick, left, right, up, down, attack, pery, hit;
  logic [2:0] state;
  logic [9:0] x_pos;
  logic [6:0] y_off;
  logic       facing_right, attack_active, parry_active, parry_success;

  localparam int F_STATE = 0;
  localparam int F_X     = 1;
  localparam int F_Y     = 2;
  localparam int F_FACE  = 3;
  localparam int F_AACT  = 4;
  localparam int F_PACT  = 5;
  localparam int F_PSUC  = 6;

  typedef struct {
    string tag;
    int    field;
    int    value;
  } exp_t;

  exp_t sb[$];
  int   checks_total  = 0;
  int   checks_passed = 0;
  int   step_no       = 0;

  always #5 clk = ~clk;

  player_action_fsm dut (
    .clk           (clk),
    .reset         (reset),
    .tick          (tick),
    .left          (left),
    .right         (right),
    .up            (up),
    .down          (down),
    .attack        (attack),
    .pery          (pery),
    .hit           (hit),
    .state         (state),
    .x_pos         (x_pos),
    .y_off         (y_off),
    .facing_right  (facing_right),
    .attack_active (attack_active),
    .parry_active  (parry_active),
    .parry_success (parry_success)
  );

  task automatic check_eq(input string tag, input int obs, input int expv);
    checks_total++;
    if (obs == expv) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int get_field(input int f);
    case (f)
      F_STATE: return int'(state);
      F_X:     return int'(x_pos);
      F_Y:     return int'(y_off);
      F_FACE:  return int'(facing_right);
      F_AACT:  return int'(attack_active);
      F_PACT:  return int'(parry_active);
      F_PSUC:  return int'(parry_success);
      default: return -1;
    endcase
  endfunction

  task automatic push(input string tag, input int field, input int value);
    exp_t e;
    e.tag   = tag;
    e.field = field;
    e.value = value;
    sb.push_back(e);
  endtask

  task automatic push_core(input string tag, input int st, input int x, input int y, input int face);
    push({tag, ".state"}, F_STATE, st);
    push({tag, ".x"},     F_X,     x);
    push({tag, ".y"},     F_Y,     y);
    push({tag, ".face"},  F_FACE,  face);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(e.tag, get_field(e.field), e.value);
    end
  endtask

  // One clock step with the given tick value; outputs are sampled 1 ns after
  // the rising edge, well away from either clock edge.
  task automatic cyc(input logic t);
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
    step_no++;
    $display("step %0d tick=%0b rst=%0b L%0b R%0b U%0b A%0b P%0b H%0b -> state=%0d x=%0d y=%0d face=%0b aa=%0b pa=%0b ps=%0b",
             step_no, t, reset, left, right, up, attack, pery, hit,
             state, x_pos, y_off, facing_right, attack_active, parry_active, parry_success);
    drain();
  endtask

  task automatic do_reset(input string tag, input logic t);
    reset = 1'b1;
    push_core(tag, 0, 100, 0, 1);
    push({tag, ".aact"}, F_AACT, 0);
    push({tag, ".pact"}, F_PACT, 0);
    push({tag, ".psuc"}, F_PSUC, 0);
    cyc(t);
    reset = 1'b0;
  endtask

  initial begin
    int xe;
    int ye;
    reset = 1'b1; tick = 1'b0;
    left = 1'b0; right = 1'b0; up = 1'b0; down = 1'b0;
    attack = 1'b0; pery = 1'b0; hit = 1'b0;
    @(posedge clk);
    #1;

    // Reset is honoured even on a tick cycle.
    do_reset("rst0", 1'b1);

    // Walk right 5 ticks: 100 -> 120.
    right = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      push($sformatf("walkR%0d.state", i), F_STATE, 2);
      push($sformatf("walkR%0d.x", i),     F_X,     100 + 4 * i);
      push($sformatf("walkR%0d.face", i),  F_FACE,  1);
      cyc(1'b1);
    end
    // No tick: everything holds.
    push("hold.state", F_STATE, 2);
    push("hold.x",     F_X,     120);
    cyc(1'b0);
    right = 1'b0;
    push("release.state", F_STATE, 0);
    push("release.x",     F_X,     120);
    cyc(1'b1);
    // Both directions pressed -> IDLE, no movement.
    left = 1'b1; right = 1'b1;
    push("both.state", F_STATE, 0);
    push("both.x",     F_X,     120);
    cyc(1'b1);
    right = 1'b0;

    // Walk left into the left wall and keep pushing.
    for (int i = 1; i <= 29; i++) begin
      xe = 120 - 4 * i;
      if (xe < 16) xe = 16;
      push($sformatf("walkL%0d.x", i),     F_X,     xe);
      push($sformatf("walkL%0d.state", i), F_STATE, 1);
      push($sformatf("walkL%0d.face", i),  F_FACE,  0);
      cyc(1'b1);
    end
    left = 1'b0;
    push("walkL_rel.state", F_STATE, 0);
    push("walkL_rel.x",     F_X,     16);
    cyc(1'b1);

    // Jump: one tick of up, then 16 airborne ticks.
    do_reset("rst1", 1'b0);
    up = 1'b1;
    push("jump0.state", F_STATE, 3);
    push("jump0.y",     F_Y,     0);
    cyc(1'b1);
    up = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      ye = (k <= 8) ? 4 * k : 4 * (16 - k);
      push($sformatf("jump%0d.y", k),     F_Y,     ye);
      push($sformatf("jump%0d.state", k), F_STATE, (k < 16) ? 3 : 0);
      cyc(1'b1);
    end
    push_core("jump17", 0, 100, 0, 1);
    cyc(1'b1);

    // Attack: 12 ticks active, held button never retriggers.
    attack = 1'b1;
    push("atk0.state", F_STATE, 5);
    push("atk0.aact",  F_AACT,  1);
    cyc(1'b1);
    for (int n = 1; n <= 11; n++) begin
      push($sformatf("atk%0d.aact", n), F_AACT, 1);
      push($sformatf("atk%0d.x", n),    F_X,    100);
      cyc(1'b1);
    end
    push("atk_exit.state", F_STATE, 0);
    push("atk_exit.aact",  F_AACT,  0);
    cyc(1'b1);
    // Cooldown window: held, released, edge ignored at 5, edge taken at 11.
    for (int n = 1; n <= 11; n++) begin
      attack = (n <= 3) || (n == 5) || (n == 11);
      push($sformatf("cool%0d.state", n), F_STATE, (n == 11) ? 5 : 0);
      push($sformatf("cool%0d.aact", n),  F_AACT,  (n == 11) ? 1 : 0);
      cyc(1'b1);
    end
    attack = 1'b0;

    // Parry with a hit on its 3rd tick.
    do_reset("rst2", 1'b0);
    pery = 1'b1;
    push("par0.state", F_STATE, 6);
    push("par0.pact",  F_PACT,  1);
    push("par0.psuc",  F_PSUC,  0);
    cyc(1'b1);
    pery = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      hit = (n == 3);
      push($sformatf("par%0d.state", n), F_STATE, (n < 8) ? 6 : 0);
      push($sformatf("par%0d.pact", n),  F_PACT,  (n < 8) ? 1 : 0);
      push($sformatf("par%0d.psuc", n),  F_PSUC,  (n == 3) ? 1 : 0);
      cyc(1'b1);
      if (n == 3) begin
        hit = 1'b0;
        push("par3b.psuc",  F_PSUC,  0);
        push("par3b.state", F_STATE, 6);
        cyc(1'b0);
      end
    end
    hit = 1'b0;

    // Hit while idle facing right at 100 -> knocked to 76.
    hit = 1'b1;
    push_core("hit0", 7, 76, 0, 1);
    cyc(1'b1);
    push("hit1.state", F_STATE, 7);
    push("hit1.x",     F_X,     76);
    cyc(1'b1);
    hit = 1'b0;
    for (int n = 2; n <= 16; n++) begin
      push($sformatf("hit%0d.state", n), F_STATE, (n < 16) ? 7 : 0);
      push($sformatf("hit%0d.x", n),     F_X,     76);
      cyc(1'b1);
    end

    // Hit during a jump clears height and knocks back.
    up = 1'b1;
    push("jhit0.state", F_STATE, 3);
    cyc(1'b1);
    up = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      push($sformatf("jhit_air%0d.y", k), F_Y, 4 * k);
      cyc(1'b1);
    end
    hit = 1'b1;
    push_core("jhit", 7, 52, 0, 1);
    cyc(1'b1);
    hit = 1'b0;

    // Reset mid-jump with tick low.
    do_reset("rst3", 1'b0);
    right = 1'b1;
    cyc(1'b1);
    push("mj_walk.x", F_X, 108);
    cyc(1'b1);
    right = 1'b0;
    up = 1'b1;
    push("mj0.state", F_STATE, 3);
    cyc(1'b1);
    up = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      push($sformatf("mj%0d.y", k), F_Y, 4 * k);
      cyc(1'b1);
    end
    do_reset("rst_midjump", 1'b0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/player_action_fsm.md
PLAYER_ACTION_FSM -- requirements
Module: player_action_fsm

Interface
REQ-001 SHALL have parameter X_MIN, default 10'd16, leftmost legal x_pos.
REQ-002 SHALL have parameter X_MAX, default 10'd560, rightmost legal x_pos.
REQ-003 SHALL have parameter X_START, default 10'd100, x_pos after reset.
REQ-004 SHALL have parameter WALK_STEP, default 4, pixels moved per tick while walking or airborne.
REQ-005 SHALL have parameter ATTACK_TICKS, default 12, ATTACK state length in ticks.
REQ-006 SHALL have parameter PARRY_TICKS, default 8, PARRY state length in ticks.
REQ-007 SHALL have parameter HIT_TICKS, default 16, HITSTUN length in ticks.
REQ-008 SHALL have parameter KNOCKBACK, default 24, pixels pushed back on hit.
REQ-009 SHALL have parameter COOLDOWN_TICKS, default 10, ticks after ATTACK exit during which attack is ignored.
REQ-010 SHALL have port clk  input  1  system clock; the block is single-clock.
REQ-011 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-012 SHALL have port tick  input  1  one-cycle frame strobe; all state and position updates occur only on tick=1 cycles.
REQ-013 SHALL have ports left, right, up, down, attack, pery  input  1 each  active-high debounced controller levels.
REQ-014 SHALL have port hit  input  1  active-high level from collision logic, sampled on ticks.
REQ-015 SHALL have port state  output  3  IDLE=0, WALK_L=1, WALK_R=2, JUMP=3, CROUCH=4, ATTACK=5, PARRY=6, HITSTUN=7.
REQ-016 SHALL have ports x_pos  output  10 and y_off  output  7  (height above ground).
REQ-017 SHALL have ports facing_right, attack_active, parry_active, parry_success  output  1 each.

Function
REQ-018 On non-tick cycles all registers SHALL hold.
REQ-019 attack SHALL be edge-qualified: it triggers only when high on a tick and low on the previous tick; holding it SHALL NOT retrigger.
REQ-020 From IDLE/WALK_L/WALK_R/CROUCH, next state priority SHALL be: hit -> HITSTUN; attack edge with cooldown=0 -> ATTACK; pery -> PARRY; up -> JUMP; down -> CROUCH; left only -> WALK_L; right only -> WALK_R; else (including left&right) -> IDLE.
REQ-021 WALK_L/WALK_R SHALL move x_pos by WALK_STEP per tick, saturating at X_MIN/X_MAX, and set facing_right to 0/1.
REQ-022 JUMP SHALL last 16 ticks: y_off +4 per tick for ticks 1..8, -4 for ticks 9..16, returning to IDLE with y_off=0; left/right (not both) SHALL move x_pos as in REQ-021; attack, pery, down ignored.
REQ-023 ATTACK SHALL last ATTACK_TICKS ticks with attack_active=1 throughout, no movement, then IDLE; cooldown counter SHALL load COOLDOWN_TICKS on exit and decrement per tick to 0.
REQ-024 PARRY SHALL last PARRY_TICKS ticks with parry_active=1, then IDLE; hit during PARRY SHALL NOT leave PARRY and SHALL pulse parry_success for exactly one clock cycle (the tick cycle's next cycle).
REQ-025 hit in any state except PARRY and HITSTUN SHALL enter HITSTUN, clear y_off to 0, abort the current counter, and move x_pos KNOCKBACK opposite to facing_right, saturating at X_MIN/X_MAX.
REQ-026 HITSTUN SHALL last HIT_TICKS ticks, ignore all inputs including hit, then IDLE.
REQ-027 attack_active and parry_active SHALL be registered decodes of state; latency from deciding tick to output SHALL be one clock.

Reset
REQ-028 reset=1 on a clock edge SHALL, regardless of tick or state (including mid-JUMP or mid-HITSTUN), set state=IDLE, x_pos=X_START, y_off=0, facing_right=1, cooldown=0, all counters=0, previous-attack register=0, attack_active=parry_active=parry_success=0.

Verification
REQ-029 Reset, hold right for 5 ticks -> state=2, x_pos=120, facing_right=1; release -> state=0 next tick.
REQ-030 x_pos at 16, hold left 3 ticks -> x_pos stays 16, state=1, facing_right=0.
REQ-031 Press up one tick -> y_off 4,8..32 then 28..0 over 16 ticks, state=0 on tick 17.
REQ-032 Attack edge -> attack_active=1 for 12 ticks; attack held high throughout and after -> no second ATTACK; new edge within 10 ticks ignored, edge at tick 11 after exit accepted.
REQ-033 PARRY with hit on tick 3 -> parry_success single-cycle pulse, state stays 6; hit while IDLE at x_pos=100 facing right -> state=7, x_pos=76, returns 0 after 16 ticks.
REQ-034 reset asserted mid-JUMP with y_off=20 and tick=0 -> next cycle state=0, y_off=0, x_pos=100.
